// File: rtl/pe_bus_pkg.sv
// Shared definitions for the PE bus arbiter.
//   arb_state_t : arbiter FSM states
//   DefaultNumPe / DefaultTimeout : default parameter values
//   clog2_min1  : $clog2 clamped to at least 1 bit (for index widths)
package pe_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT
  } arb_state_t;

  localparam int unsigned DefaultNumPe   = 4;
  localparam int unsigned DefaultTimeout = 16;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector, bit i from requester i
//   ptr   : highest-priority index for this round
//   found : at least one request present
//   idx   : first requester at or after ptr, wrapping modulo NUM_PE
module rr_picker
  import pe_bus_pkg::*;
#(
  parameter int unsigned NUM_PE = DefaultNumPe,
  localparam int unsigned IDW   = clog2_min1(NUM_PE)
) (
  input  logic [NUM_PE-1:0] req,
  input  logic [IDW-1:0]    ptr,
  output logic              found,
  output logic [IDW-1:0]    idx
);

  logic [2*NUM_PE-1:0] req_dbl;
  logic [2*NUM_PE-1:0] masked;

  always_comb begin
    req_dbl = {req, req};
    masked  = '0;
    found   = 1'b0;
    idx     = '0;
    // Clear positions below ptr; the upper copy supplies the wrapped-around candidates.
    for (int unsigned j = 0; j < 2 * NUM_PE; j++) begin
      masked[j] = req_dbl[j] && (j >= 32'(ptr));
    end
    for (int unsigned j = 0; j < 2 * NUM_PE; j++) begin
      if (!found && masked[j]) begin
        found = 1'b1;
        idx   = (j >= NUM_PE) ? IDW'(j - NUM_PE) : IDW'(j);
      end
    end
  end

endmodule

// File: rtl/pe_bus_arbiter.sv
// Round-robin arbiter for the shared global-memory / register-file bus.
//   clk           : system clock, rising edge
//   reset         : asynchronous active-low reset
//   bus_request   : per-PE request lines
//   mem_ackBus    : global memory transaction complete
//   data_ReadyBus : local register read complete
//   grant         : one-cycle one-hot grant pulse to the winner
//   grant_id      : index of current / last owner
//   bus_busy      : bus owned, from grant cycle through the release edge
//   timeout_err   : one-cycle pulse when the owner is released by timeout
module pe_bus_arbiter
  import pe_bus_pkg::*;
#(
  parameter int unsigned NUM_PE  = DefaultNumPe,
  parameter int unsigned TIMEOUT = DefaultTimeout,
  localparam int unsigned IDW    = clog2_min1(NUM_PE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PE-1:0] bus_request,
  input  logic              mem_ackBus,
  input  logic              data_ReadyBus,
  output logic [NUM_PE-1:0] grant,
  output logic [IDW-1:0]    grant_id,
  output logic              bus_busy,
  output logic              timeout_err
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [IDW-1:0]  IdLast  = IDW'(NUM_PE - 1);

  arb_state_t        state_q, state_d;
  logic [NUM_PE-1:0] grant_q, grant_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic              bus_busy_q, bus_busy_d;
  logic              timeout_err_q, timeout_err_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;

  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic [IDW-1:0]    ptr_after_owner;
  logic              done;

  rr_picker #(
    .NUM_PE(NUM_PE)
  ) u_rr_picker (
    .req  (bus_request),
    .ptr  (rr_ptr_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  assign done            = mem_ackBus | data_ReadyBus;
  assign ptr_after_owner = (grant_id_q == IdLast) ? '0 : grant_id_q + IDW'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = '0;
    grant_id_d    = grant_id_q;
    bus_busy_d    = bus_busy_q;
    timeout_err_d = 1'b0;
    rr_ptr_d      = rr_ptr_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d[pick_idx] = 1'b1;
          grant_id_d        = pick_idx;
          bus_busy_d        = 1'b1;
          state_d           = GRANT;
        end
      end
      // Completion strobes are ignored here: the PE interface only latches on grant.
      GRANT: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (done || (wait_cnt_q == CntLast)) begin
          // Completion takes precedence over a coincident timeout.
          timeout_err_d = !done;
          bus_busy_d    = 1'b0;
          rr_ptr_d      = ptr_after_owner;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      bus_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      bus_busy_q    <= bus_busy_d;
      timeout_err_q <= timeout_err_d;
      rr_ptr_q      <= rr_ptr_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign bus_busy    = bus_busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/pe_bus_arbiter.md
Name: pe_bus_arbiter

Overview:
- Shares the single global-memory/register-file bus between NUM_PE processing-element bus interfaces.
- Runs round-robin arbitration over their bus_request lines and issues a one-cycle grant pulse to the winner.
- Holds the bus until the transaction completes, signalled by mem_ackBus or data_ReadyBus, or until a timeout expires.
- Sits between the PE bus_interface instances and the shared bus/memory controller.

Parameters:
- NUM_PE, 4, number of requesting PEs (>=1).
- TIMEOUT, 16, max cycles in WAIT before forced release (>=2).
- IDW, $clog2(NUM_PE) (min 1), width of grant_id; localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- bus_request  input  NUM_PE  per-PE request, bit i from PE i.
- mem_ackBus  input  1  global memory transaction complete.
- data_ReadyBus  input  1  local register read complete.
- grant  output  NUM_PE  one-hot grant pulse, one cycle.
- grant_id  output  IDW  index of current/last owner.
- bus_busy  output  1  bus owned; high from grant cycle through the release edge.
- timeout_err  output  1  one-cycle pulse when a transaction is released by timeout.

Behaviour:
- All outputs are registered. State is IDLE, GRANT or WAIT. Internal state: rr_ptr (IDW bits) and wait_cnt ($clog2(TIMEOUT)+1 bits).
- Reset (reset=0, async): state=IDLE, grant=0, grant_id=0, bus_busy=0, timeout_err=0, rr_ptr=0, wait_cnt=0. Reset mid-transaction aborts immediately; there is no completion pulse.
- IDLE:
  - If |bus_request at the clock edge, winner = first i with bus_request[i]=1, searching rr_ptr, rr_ptr+1, … and wrapping modulo NUM_PE.
  - At that edge: grant[winner]=1, grant_id=winner, bus_busy=1, state=GRANT.
  - Latency: request sampled at edge k gives grant visible in cycle k..k+1.
  - No requests: stay IDLE, all pulses 0.
- GRANT (exactly one cycle):
  - Next edge: grant=0, wait_cnt=0, state=WAIT.
  - mem_ackBus/data_ReadyBus in this cycle are ignored, because the interface only latches on grant.
- WAIT:
  - Each edge: if mem_ackBus|data_ReadyBus then release.
  - Else if wait_cnt==TIMEOUT-1 then release with timeout_err=1 for one cycle.
  - Else wait_cnt+1.
- Release (edge):
  - state=IDLE, bus_busy=0, rr_ptr=(grant_id+1) mod NUM_PE; grant_id holds its value.
  - With NUM_PE=1, rr_ptr stays 0.
- Simultaneous completion and timeout at wait_cnt==TIMEOUT-1: completion wins, timeout_err=0.
- Both mem_ackBus and data_ReadyBus high together: a single release.
- Requests arriving while state≠IDLE are not acted on; they are re-evaluated in IDLE.
- After release there is a mandatory single IDLE cycle, so back-to-back grants are ≥3 cycles apart: GRANT, WAIT≥1, IDLE.
- A requester deasserting before being sampled in IDLE is simply not granted.
- grant is always one-hot or zero. Grant is never issued while bus_busy is already 1.
- Fairness: a continuously requesting PE is granted within NUM_PE arbitration rounds.

Decomposition:
- Shared package pe_bus_pkg:
  - arb_state_t enum {IDLE, GRANT, WAIT}.
  - Default NUM_PE/TIMEOUT constants.
  - Function clog2_min1.
- Sub-module rr_picker: purely combinational.
  - Inputs: req[NUM_PE], ptr[IDW].
  - Outputs: found, idx[IDW].
  - Implementation: double-width mask-and-find-first.
- Arbiter FSM, counter and pointer stay in pe_bus_arbiter.

Test Plan:
- Reset then bus_request=4'b0000 for 5 cycles -> grant=0, bus_busy=0, state IDLE throughout.
- bus_request=4'b0100; mem_ackBus pulse 3 cycles after grant -> grant=4'b0100 one cycle, grant_id=2, bus_busy high 4 cycles, rr_ptr=3 after release.
- All four requesting continuously, each completion via data_ReadyBus 2 cycles after grant -> grant order 0,1,2,3,0 with grant_id sequence 0,1,2,3,0.
- Single request, no acks, TIMEOUT=16 -> release after 16 WAIT cycles, timeout_err one-cycle pulse, next request granted normally.
- mem_ackBus held high during the GRANT cycle only -> ignored, arbiter stays in WAIT; ack on wait_cnt==TIMEOUT-1 releases with timeout_err=0.
- reset asserted mid-WAIT with bus_request=4'b1010 -> all outputs 0 asynchronously; after deassert, PE1 granted first (rr_ptr=0).
